// File: rtl/seq_match_ctrl.sv
// rtl/seq_match_ctrl.sv - serial pattern matcher scanning parallel words MSB first
// Optional feature: define SEQ_NONOVERLAP_EN for non-overlapping match detection.
module seq_match_ctrl #(
  parameter int               WORD_W   = 8,
  parameter int               PAT_W    = 5,
  parameter logic [PAT_W-1:0] PAT_INIT = 5'b10110,
  parameter int               CNT_W    = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pat_load,
  input  logic [PAT_W-1:0]  pat_in,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              z,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  match_cnt
);

  localparam int IDX_W  = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam int FILL_W = $clog2(PAT_W + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
  localparam logic [FILL_W-1:0] FILL_THR  = FILL_W'(PAT_W - 1);
  localparam logic [IDX_W-1:0]  IDX_FIRST = IDX_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

  logic [1:0]        state;
  logic [PAT_W-1:0]  pattern;
  logic [PAT_W-2:0]  hist;
  logic [FILL_W-1:0] fill;
  logic [WORD_W-1:0] data;
  logic [IDX_W-1:0]  bit_idx;
  logic [CNT_W-1:0]  cnt;

  logic              cur_bit;
  logic [PAT_W-1:0]  window;
  logic              hit;

  assign cur_bit = data[bit_idx];
  assign window  = {hist, cur_bit};
  // fill gating keeps stale zeros after reset/load from forming a false match
  assign hit     = (state == SHIFT) && (window == pattern) && (fill >= FILL_THR);

  // outputs are forced quiet while reset is asserted, whatever state is held
  assign z         = hit && !rst;
  assign busy      = (state != IDLE) && !rst;
  assign done      = (state == DONE) && !rst;
  assign in_ready  = ((state == IDLE) || rst) && !pat_load;
  assign match_cnt = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pattern <= PAT_INIT;
      hist    <= '0;
      fill    <= '0;
      data    <= '0;
      bit_idx <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pat_load) begin
            pattern <= pat_in;
            hist    <= '0;
            fill    <= '0;
          end else if (in_valid) begin
            data    <= in_data;
            cnt     <= '0;
            bit_idx <= IDX_FIRST;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          hist <= window[PAT_W-2:0];
`ifdef SEQ_NONOVERLAP_EN
          if (hit)
            fill <= '0;
          else if (fill != FILL_FULL)
            fill <= fill + 1'b1;
`else
          if (fill != FILL_FULL)
            fill <= fill + 1'b1;
`endif
          if (hit && (cnt != CNT_MAX))
            cnt <= cnt + 1'b1;
          if (bit_idx == '0)
            state <= DONE;
          else
            bit_idx <= bit_idx - 1'b1;
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_match_ctrl.sv
// tb/tb_seq_match_ctrl.sv - table-driven scoreboard bench for seq_match_ctrl
module tb_seq_match_ctrl;

`ifdef SEQ_NONOVERLAP_EN
  localparam bit NONOVL = 1'b1;
`else
  localparam bit NONOVL = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, pat_load, in_valid;
  logic [4:0] pat_in;
  logic [7:0] in_data;
  logic       in_ready, z, busy, done;
  logic [3:0] match_cnt;

  logic       s_in_valid;
  logic [1:0] s_pat_in;
  logic [7:0] s_in_data;
  logic       s_pat_load, s_in_ready, s_z, s_busy, s_done;
  logic [1:0] s_match_cnt;

  always #5 clk = ~clk;

  seq_match_ctrl dut (
    .clk(clk), .rst(rst), .pat_load(pat_load), .pat_in(pat_in),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .z(z), .busy(busy), .done(done), .match_cnt(match_cnt)
  );

  // 2-bit pattern 00 and a 2-bit counter to reach saturation in one word
  seq_match_ctrl #(.WORD_W(8), .PAT_W(2), .PAT_INIT(2'b00), .CNT_W(2)) u_sat (
    .clk(clk), .rst(rst), .pat_load(s_pat_load), .pat_in(s_pat_in),
    .in_valid(s_in_valid), .in_data(s_in_data), .in_ready(s_in_ready),
    .z(s_z), .busy(s_busy), .done(s_done), .match_cnt(s_match_cnt)
  );

  typedef struct {
    logic       load;
    logic [4:0] pat;
    logic [7:0] word;
    logic [7:0] zov;
    logic [3:0] cov;
    logic [7:0] zno;
    logic [3:0] cno;
    logic       mid;
  } vec_t;

  typedef struct {
    logic [7:0] zexp;
    logic [3:0] cnt;
  } exp_t;

  vec_t vecs[7];
  exp_t sb[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // zexp bit 7 is the first SHIFT cycle, bit 0 the last
  task automatic run_word(input vec_t v, input string tag);
    exp_t       e;
    logic [7:0] zgot;
    int         bad;
    if (v.load) begin
      @(posedge clk); #1;
      pat_load = 1'b1; pat_in = v.pat;
      @(negedge clk);
      check({tag, " load in_ready"}, 32'(in_ready), 32'd0);
      @(posedge clk); #1;
      pat_load = 1'b0;
    end else begin
      @(posedge clk); #1;
    end
    in_valid = 1'b1; in_data = v.word;
    @(negedge clk);
    check({tag, " in_ready"}, 32'(in_ready), 32'd1);
    sb.push_back('{NONOVL ? v.zno : v.zov, NONOVL ? v.cno : v.cov});
    @(posedge clk); #1;
    in_valid = 1'b0; in_data = 8'($urandom);
    if (v.mid) begin
      pat_load = 1'b1; pat_in = 5'b11111;
    end
    zgot = '0; bad = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      zgot[8-i] = z;
      if (busy !== 1'b1 || done !== 1'b0) bad++;
    end
    @(posedge clk); #1;
    pat_load = 1'b0;
    @(negedge clk);
    check({tag, " done"}, 32'(done), 32'd1);
    check({tag, " z in DONE"}, 32'(z), 32'd0);
    if (sb.size() == 0) begin
      check({tag, " scoreboard empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, " z pattern"}, 32'(zgot), 32'(e.zexp));
      check({tag, " match_cnt"}, 32'(match_cnt), 32'(e.cnt));
      check({tag, " busy/done in SHIFT"}, 32'(bad), 32'd0);
      @(negedge clk);
      check({tag, " idle in_ready"}, 32'(in_ready), 32'd1);
      check({tag, " idle busy"}, 32'(busy), 32'd0);
      check({tag, " cnt hold"}, 32'(match_cnt), 32'(e.cnt));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int saw;
    vec_t w;

    vecs[0] = '{1'b0, 5'b00000, 8'b10110110, 8'b00001001, 4'd2, 8'b00001000, 4'd1, 1'b0};
    vecs[1] = '{1'b1, 5'b10110, 8'b00000101, 8'b00000000, 4'd0, 8'b00000000, 4'd0, 1'b0};
    vecs[2] = '{1'b0, 5'b00000, 8'b10000000, 8'b01000000, 4'd1, 8'b01000000, 4'd1, 1'b0};
    vecs[3] = '{1'b1, 5'b00000, 8'b00000000, 8'b00001111, 4'd4, 8'b00001000, 4'd1, 1'b0};
    vecs[4] = '{1'b0, 5'b00000, 8'b11111111, 8'b00000000, 4'd0, 8'b00000000, 4'd0, 1'b0};
    vecs[5] = '{1'b1, 5'b01010, 8'b10101010, 8'b00000101, 4'd2, 8'b00000100, 4'd1, 1'b0};
    vecs[6] = '{1'b0, 5'b00000, 8'b10101010, 8'b01010101, 4'd4, 8'b00010000, 4'd1, 1'b0};

    rst = 1'b1; pat_load = 1'b0; pat_in = '0; in_valid = 1'b1; in_data = 8'hB6;
    s_pat_load = 1'b0; s_pat_in = '0; s_in_valid = 1'b0; s_in_data = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset z", 32'(z), 32'd0);
    check("reset in_ready", 32'(in_ready), 32'd1);
    check("reset match_cnt", 32'(match_cnt), 32'd0);

    for (int i = 0; i < 7; i++) run_word(vecs[i], $sformatf("v%0d", i));

    // pat_load wins over in_valid in IDLE
    @(posedge clk); #1;
    pat_load = 1'b1; pat_in = 5'b00000; in_valid = 1'b1; in_data = 8'h00;
    @(negedge clk);
    check("prio in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    pat_load = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    check("prio word not taken", 32'(busy), 32'd0);
    w = '{1'b0, 5'b00000, 8'h00, 8'b00001111, 4'd4, 8'b00001000, 4'd1, 1'b0};
    run_word(w, "prio");
    w = '{1'b0, 5'b00000, 8'h00, 8'b11111111, 4'd8, 8'b01000010, 4'd2, 1'b1};
    run_word(w, "midload");

    // reset in the 3rd SHIFT cycle aborts the word
    @(posedge clk); #1;
    in_valid = 1'b1; in_data = 8'h00;
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check("abort busy before rst", 32'(busy), 32'd1);
    check("abort cnt before rst", 32'(match_cnt), NONOVL ? 32'd0 : 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    check("abort busy in rst", 32'(busy), 32'd0);
    check("abort done in rst", 32'(done), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort busy", 32'(busy), 32'd0);
    check("abort done", 32'(done), 32'd0);
    check("abort in_ready", 32'(in_ready), 32'd1);
    check("abort match_cnt", 32'(match_cnt), 32'd0);
    saw = 0;
    repeat (12) begin
      @(negedge clk);
      if (done === 1'b1) saw++;
    end
    check("abort no done", 32'(saw), 32'd0);
    run_word(vecs[0], "post_rst");

    // counter saturation on the 2-bit counter instance
    @(posedge clk); #1;
    s_in_valid = 1'b1; s_in_data = 8'h00;
    @(posedge clk); #1;
    s_in_valid = 1'b0;
    repeat (8) @(negedge clk);
    @(negedge clk);
    check("sat done", 32'(s_done), 32'd1);
    check("sat match_cnt", 32'(s_match_cnt), 32'd3);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seq_match_ctrl.md
SEQ_MATCH_CTRL -- requirements
Module: seq_match_ctrl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  WORD_W    8         bits per parallel input word
  PAT_W     5         pattern length in bits, 2..WORD_W
  PAT_INIT  5'b10110  pattern value after reset
  CNT_W     4         match counter width
REQ-002 Ports SHALL be, one per line: name  direction  width  meaning.
  clk        input   1       single clock, all state on rising edge
  rst        input   1       synchronous, active-high reset
  pat_load   input   1       load new pattern from pat_in
  pat_in     input   PAT_W   pattern value, MSB is the oldest bit
  in_valid   input   1       parallel word offered
  in_data    input   WORD_W  word, serialised MSB first
  in_ready   output  1       word accepted when in_valid && in_ready
  z          output  1       Mealy match pulse, one per completed pattern
  busy       output  1       high in SHIFT and DONE states
  done       output  1       one-cycle pulse, word fully scanned
  match_cnt  output  CNT_W   matches found in the current or last word

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-004 In IDLE, in_ready SHALL equal !pat_load, and busy SHALL be 0.
REQ-005 In IDLE, pat_load SHALL load pat_in and clear the history and the fill count. pat_load SHALL take priority over in_valid in the same cycle. pat_load SHALL be ignored outside IDLE.
REQ-006 On word acceptance at edge N, the block SHALL capture in_data, clear match_cnt, set bit_idx to WORD_W-1 and enter SHIFT.
REQ-007 SHIFT SHALL present one bit per cycle, in_data[bit_idx], in cycles N+1 to N+WORD_W. It SHALL then enter DONE.
REQ-008 In cycle N+WORD_W+1, the block SHALL be in DONE and SHALL assert done. It SHALL return to IDLE at the next edge, so in_ready is high again in cycle N+WORD_W+2.
REQ-009 In a SHIFT cycle, z SHALL be driven combinationally and SHALL be 1 only when both conditions hold: {hist[PAT_W-2:0], cur_bit} == pattern, and fill >= PAT_W-1. In all other states, z SHALL be 0.
REQ-010 Each SHIFT cycle SHALL shift cur_bit into hist and SHALL increment fill, saturating at PAT_W.
REQ-011 History SHALL persist across words, so matches may span word boundaries. Only rst and pat_load SHALL clear it.
REQ-012 Each z pulse SHALL increment match_cnt, saturating at 2^CNT_W-1 with no wrap.
REQ-013 match_cnt SHALL hold its value through DONE and IDLE until the next word is accepted.

Reset
REQ-014 When rst is 1 at a clock edge, in any state including mid-SHIFT, the block SHALL reset to: state IDLE, pattern PAT_INIT, hist 0, fill 0, match_cnt 0, bit_idx 0.
REQ-015 During and after reset, the outputs SHALL be: z=0, done=0, busy=0, in_ready=1 (when pat_load=0).
REQ-016 An in_valid that is high in the reset cycle SHALL NOT be accepted.

Configuration
REQ-017 Macro SEQ_NONOVERLAP_EN defined: on each z pulse, the block SHALL clear fill to 0, so the next match needs PAT_W fresh bits (non-overlapping detection).
REQ-018 Macro SEQ_NONOVERLAP_EN undefined: on a z pulse, fill SHALL saturate as normal, giving overlapping detection.

Verification
REQ-019 A bench SHALL cover the following directed scenarios.
  - Reset default pattern 10110, word 8'b10110110: z pulses on the 5th and 8th bit cycles, match_cnt=2, done in cycle N+9. With SEQ_NONOVERLAP_EN: one pulse on the 5th bit, match_cnt=1.
  - Words 8'b00000101 then 8'b10000000: word 1 gives match_cnt=0; word 2 gives z on its 2nd bit cycle and match_cnt=1 (cross-word match).
  - pat_load with pat_in=5'b00000, then word 8'h00: z on bits 5-8, match_cnt=4 (SEQ_NONOVERLAP_EN: 1). The absence of a match on bits 1-4 proves the fill gating.
  - CNT_W=2, pattern 00000, word 8'h00: match_cnt saturates at 3.
  - pat_load and in_valid asserted together in IDLE: pattern loads, in_ready=0, word not taken. pat_load during SHIFT: pattern unchanged.
  - rst pulsed at the 3rd SHIFT cycle: next cycle IDLE, busy=0, done=0, match_cnt=0, pattern=10110. No done pulse ever appears for the aborted word.
